// File: rtl/divider_top.sv
// Unsigned divider by repeated subtraction; operands arrive serially after a start pulse.
// Latency: Q+4 edges after start (4 for divide-by-zero); no backpressure, start is ignored while busy.
module divider_top #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_CALC,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] quot_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] dvsr_q;
    logic             dz_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            quot_q  <= '0;
            rem_q   <= '0;
            dvsr_q  <= '0;
            dz_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) state_q <= S_LOAD_A;
                end
                S_LOAD_A: begin
                    rem_q   <= data_in;
                    quot_q  <= '0;
                    dz_q    <= 1'b0;
                    state_q <= S_LOAD_B;
                end
                S_LOAD_B: begin
                    dvsr_q  <= data_in;
                    state_q <= S_CALC;
                end
                S_CALC: begin
                    // Zero divisor short-circuits with a saturated quotient and the dividend kept as remainder.
                    if (dvsr_q == '0) begin
                        quot_q  <= '1;
                        dz_q    <= 1'b1;
                        state_q <= S_DONE;
                    end else if (rem_q >= dvsr_q) begin
                        rem_q  <= rem_q - dvsr_q;
                        quot_q <= quot_q + WIDTH'(1);
                    end else begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (start) state_q <= S_LOAD_A;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy      = (state_q == S_LOAD_A) || (state_q == S_LOAD_B) || (state_q == S_CALC);
    assign done      = (state_q == S_DONE);
    assign div_zero  = dz_q;
    assign quotient  = quot_q;
    assign remainder = rem_q;

endmodule

// File: tb/tb_divider_top.sv
// Directed bench for divider_top: arithmetic model of quotient/remainder/latency plus a per-cycle compare process.
module tb_divider_top;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] data_in;
    logic         busy;
    logic         done;
    logic         div_zero;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;

    int n_chk  = 0;
    int n_fail = 0;

    // Edge count since the edge that samples start (edge 1), and the model's expectations.
    int ecnt    = 0;
    bit track   = 1'b0;
    int exp_q   = 0;
    int exp_r   = 0;
    int exp_dz  = 0;
    int exp_lat = 0;

    divider_top #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .data_in  (data_in),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .quotient (quotient),
        .remainder(remainder)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (track) ecnt++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d, t=%0t)", nm, act, exp, ecnt, $time);
        end
    endtask

    // Plain arithmetic statement of the result and of when done must rise.
    function automatic void model(input int a, input int b);
        if (b == 0) begin
            exp_q   = (1 << W) - 1;
            exp_r   = a;
            exp_dz  = 1;
            exp_lat = 4;
        end else begin
            exp_q   = a / b;
            exp_r   = a % b;
            exp_dz  = 0;
            exp_lat = 4 + a / b;
        end
    endfunction

    always @(negedge clk) begin
        if (track && !rst && ecnt >= 1) begin
            chk("busy", 32'(busy), 32'(ecnt < exp_lat));
            chk("done", 32'(done), 32'(ecnt >= exp_lat));
            if (ecnt >= exp_lat) begin
                chk("quotient",  32'(quotient),  32'(exp_q));
                chk("remainder", 32'(remainder), 32'(exp_r));
                chk("div_zero",  32'(div_zero),  32'(exp_dz));
            end
        end
    end

    // Called #1 after a posedge; returns #1 after the edge that enters DONE.
    task automatic run_op(input int a, input int b, input int lq, input int lr,
                          input int ldz, input int llat, input bit poke);
        model(a, b);
        chk("lat_lit", 32'(exp_lat), 32'(llat));
        ecnt  = 0;
        track = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        data_in = W'(a);
        @(posedge clk); #1;
        data_in = W'(b);
        @(posedge clk); #1;
        data_in = W'($urandom);
        while (ecnt < exp_lat) begin
            start = poke && (ecnt >= 5) && (ecnt <= 7);
            @(posedge clk); #1;
        end
        start = 1'b0;
        chk("done_lit", 32'(done),      32'd1);
        chk("q_lit",    32'(quotient),  32'(lq));
        chk("r_lit",    32'(remainder), 32'(lr));
        chk("dz_lit",   32'(div_zero),  32'(ldz));
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, "_busy"}, 32'(busy),      32'd0);
        chk({nm, "_done"}, 32'(done),      32'd0);
        chk({nm, "_dz"},   32'(div_zero),  32'd0);
        chk({nm, "_q"},    32'(quotient),  32'd0);
        chk({nm, "_r"},    32'(remainder), 32'd0);
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        data_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_idle("reset");
        rst = 1'b0;
        @(posedge clk); #1;
        chk_idle("idle");

        run_op(100, 7, 14, 2, 0, 18, 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        run_op(5, 9, 0, 5, 0, 4, 1'b0);
        run_op(255, 1, 255, 0, 0, 259, 1'b0);
        run_op(42, 0, 255, 42, 1, 4, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        run_op(0, 3, 0, 0, 0, 4, 1'b0);
        run_op(20, 4, 5, 0, 0, 9, 1'b0);

        // Abort 200/3 with reset on edge 10, in the middle of CALC.
        model(200, 3);
        ecnt  = 0;
        track = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        data_in = 8'd200;
        @(posedge clk); #1;
        data_in = 8'd3;
        while (ecnt < 9) begin @(posedge clk); #1; end
        track = 1'b0;
        rst   = 1'b1;
        @(posedge clk); #1;
        chk_idle("abort");
        rst = 1'b0;
        @(posedge clk); #1;
        chk_idle("post_abort");

        run_op(200, 3, 66, 2, 0, 70, 1'b1);
        @(posedge clk); #1;
        track = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
